// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h55;

    // First received byte lands in bits [31:24] when set.
    localparam bit BIG_ENDIAN = 1'b1;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit words; word_valid strobes with the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            shreg <= 24'd0;
        end else if (en) begin
            cnt   <= cnt + 2'd1;
            shreg <= BIG_ENDIAN ? {shreg[15:0], data} : {data, shreg[23:8]};
        end
    end

    // The completed word is presented combinationally so the top can register it.
    assign word_valid = en && (cnt == 2'd3);
    assign word_data  = BIG_ENDIAN ? {shreg, data} : {data, shreg};

endmodule

// File: rtl/inst_loader.sv
// Boot loader: length-prefixed byte stream in, sequential imem writes out, ACK/NAK back.
module inst_loader
    import loader_pkg::*;
#(
    parameter int         DEPTH    = 15001,
    parameter int         ADDR_W   = 14,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic              loading,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state, state_nxt;
    logic        byte_en;
    logic        word_valid;
    logic [31:0] word_data;
    logic [31:0] word_count;
    logic [31:0] word_idx;
    logic        last_word;
    logic        in_range;
    logic        tx_fire;

    assign byte_en   = rx_valid && ((state == S_LEN) || (state == S_DATA));
    assign last_word = (word_idx + 32'd1) == word_count;
    assign in_range  = word_idx < DEPTH_W;
    assign tx_fire   = tx_valid && tx_ready;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .en         (byte_en),
        .data       (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_LEN;
        else     state <= state_nxt;
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN:   if (word_valid) state_nxt = (word_data == 32'd0) ? S_ACK : S_DATA;
            S_DATA:  if (word_valid && last_word) state_nxt = S_ACK;
            S_ACK:   if (tx_fire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= 32'd0;
            word_idx   <= 32'd0;
            imem_we    <= 1'b0;
            imem_wa    <= '0;
            imem_wd    <= 32'd0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'd0;
            loading    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) imem_wa <= imem_wa + ADDR_W'(1);

            case (state)
                S_LEN: begin
                    if (rx_valid) loading <= 1'b1;
                    if (word_valid) begin
                        word_count <= word_data;
                        if (word_data == 32'd0) loading <= 1'b0;
                    end
                end
                S_DATA: begin
                    // Overflowed words are still consumed so the host stream stays framed.
                    if (word_valid) begin
                        word_idx <= word_idx + 32'd1;
                        if (in_range) begin
                            imem_we <= 1'b1;
                            imem_wd <= word_data;
                        end else begin
                            err <= 1'b1;
                        end
                        if (last_word) loading <= 1'b0;
                    end
                end
                S_ACK: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= err ? NAK_BYTE : ACK_BYTE;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader for the instruction memory. Receives a length-prefixed program as a byte stream from the UART receiver, packs bytes into 32-bit words, writes them sequentially into the instruction memory write port, and returns an acknowledge byte to the host. Sits between the UART RX/TX modules and the instruction memory. Holds the CPU core in a not-ready state until the whole program has been loaded.

## Interface
- DEPTH, 15001, instruction memory depth in words
- ADDR_W, 14, instruction memory address width
- ACK_BYTE, 8'hAA, byte sent to the host after a successful load
- NAK_BYTE, 8'h55, byte sent to the host after an overflowed load

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  UART TX can accept a byte this cycle
- tx_valid  out  1  tx_data is valid; held until the cycle in which tx_ready=1
- tx_data  out  8  byte to transmit
- imem_we  out  1  instruction memory write enable, one-cycle pulse
- imem_wa  out  ADDR_W  instruction memory write address
- imem_wd  out  32  instruction memory write data
- loading  out  1  high while a program is being received
- done  out  1  sticky; program loaded, CPU may start fetching
- err  out  1  sticky; program longer than DEPTH

## Operation
- Stream format: 4-byte word count N, then N words of 4 bytes each. All values are big-endian: the first byte received is bits [31:24].
- States:
  - S_LEN: collect 4 bytes into the count register. After the 4th byte, go to S_DATA, or to S_ACK if N=0.
  - S_DATA: collect 4 bytes per word. After the 4th byte of a word, write the word and increment the word counter. After word N, go to S_ACK.
  - S_ACK: drive tx_valid with ACK_BYTE, or NAK_BYTE if err=1. Go to S_DONE in the cycle where tx_valid and tx_ready are both high.
  - S_DONE: terminal. All rx_valid strobes are ignored. Only rst leaves this state.
- Byte counter is 2 bits and wraps 3→0 at each completed word. Word counter is 32 bits and is compared with N, not with DEPTH.
- Write address starts at 0 and increments by 1 per written word.
- Overflow: when word index ≥ DEPTH, the word is consumed but imem_we stays low and err is set. Loading still runs to N words so the host stream stays framed.
- loading=1 in S_LEN after the first byte, and in S_DATA.
- done=1 from entry to S_DONE onward.
- rx_valid while in S_ACK is ignored; that byte is dropped.
- rst in any state returns to S_LEN with all counters cleared and outputs at their reset values. A partially loaded program is abandoned. Memory contents are not cleared.

## Timing
- Reset values:
  - S_LEN
  - imem_we=0, imem_wa=0, imem_wd=0
  - tx_valid=0, tx_data=0
  - loading=0, done=0, err=0
- Registered outputs. imem_we pulses for exactly one cycle, one cycle after the rx_valid carrying the 4th byte of a word. imem_wa and imem_wd are valid in that same cycle.
- imem_wa advances in the cycle after the write pulse.
- Back-to-back rx_valid on consecutive cycles is supported, with no stall. The block has no backpressure on RX.
- tx_valid rises one cycle after entry to S_ACK. tx_data is stable while tx_valid=1.
- done rises one cycle after the tx handshake.

## Structure
- Shared package `loader_pkg` contains:
  - state enum (S_LEN, S_DATA, S_ACK, S_DONE)
  - ACK_BYTE and NAK_BYTE defaults
  - byte-order constant
- One sub-module is natural: `byte_packer`, a 2-bit counter plus 24-bit shift register. It emits word_valid and word_data on every 4th byte and is cleared by rst. It is reused for both the length phase and the data phase.
- Counters, the address register, and tx handshake logic stay in the top module.

## Test plan
- Reset then N=2; stream 00 00 00 02 DE AD BE EF 01 23 45 67 → imem_we pulses twice: wa=0 wd=32'hDEADBEEF, then wa=1 wd=32'h01234567. Then tx_data=8'hAA handshake, done=1, err=0.
- N=0 (00 00 00 00) → no imem_we, ACK 8'hAA sent, done=1.
- tx_ready held low for 10 cycles in S_ACK → tx_valid stays 1 with tx_data stable; done rises 1 cycle after tx_ready=1.
- DEPTH=4 override, N=6, 24 data bytes → 4 writes at wa 0..3, err=1, NAK 8'h55 sent, done=1.
- rst asserted after 5 of 8 data bytes, then a full N=1 stream AABBCCDD → single write wa=0 wd=32'hAABBCCDD, ACK sent.
- Bytes on consecutive cycles, plus extra bytes after done → no dropped word, no writes after done, state stays S_DONE.
